vga_timing_recovery: RTL and testbench
======================================

Name: vga_timing_recovery

Overview:
- Receive-side counterpart of the VGA timing generator.
- Samples incoming h_sync/v_sync (active-low, possibly asynchronous to clk) and recovers the visible-pixel coordinates and an active-video flag.
- Measures line and frame lengths and reports lock once the timing is stable.
- Sits in front of capture or test logic that consumes an external or looped-back VGA stream.

Parameters:
- h_size, 640, visible pixels per line
- h_back_porch, 48, pixel ticks from h_sync trailing edge to first visible pixel
- v_line, 480, visible lines per frame
- v_back_porch, 33, lines from v_sync trailing edge to first visible line
- max_line_ticks, 1023, saturation value of the horizontal counter (width clog2(max_line_ticks+1))
- max_frame_lines, 1023, saturation value of the vertical counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pixel_tick  in  1  one-clk enable marking a pixel sample instant
- h_sync  in  1  horizontal sync, active low, asynchronous
- v_sync  in  1  vertical sync, active low, asynchronous
- h_pixel  out  clog2(h_size)  visible column, 0 outside active video
- v_pixel  out  clog2(v_line)  visible row, 0 outside active video
- active  out  1  high during visible pixels
- locked  out  1  timing stable
- frame_start  out  1  one-clk pulse on first visible pixel of a frame (only while locked)
- line_len  out  clog2(max_line_ticks+1)  last measured ticks per line
- frame_lines  out  clog2(max_frame_lines+1)  last measured lines per frame

Behaviour:
- Reset (async, active-low): all registers 0; sync flops reset to 1 (idle level). Outputs are 0 during and after reset until the first event: h_pixel, v_pixel, active, locked, frame_start, line_len, frame_lines.
- Input conditioning:
  - Two-flop synchronizer per sync input, clocked every clk.
  - Previous-value register per input, updated only when pixel_tick=1.
- Edge detection, evaluated only when pixel_tick=1:
  - Trailing edge = synchronized value 1 while previous value is 0.
  - Leading edges are ignored.
- h_cnt, on pixel_tick:
  - h trailing edge: line_len <= h_cnt+1 (saturating); h_cnt <= 0.
  - Otherwise h_cnt increments, saturating at max_line_ticks.
- v_cnt:
  - v trailing edge sets pend_v.
  - On each h trailing edge: if pend_v (or a v trailing edge in the same tick), frame_lines <= v_cnt+1 (saturating), v_cnt <= 0, pend_v cleared.
  - Otherwise v_cnt increments, saturating at max_frame_lines.
- Active window:
  - Horizontal condition: h_back_porch <= h_cnt < h_back_porch+h_size.
  - Vertical condition: v_back_porch-1 <= v_cnt < v_back_porch-1+v_line. v_cnt=0 is the line whose pixels follow the first h trailing edge after v_sync ends.
  - active requires both conditions and locked=1.
  - h_pixel = h_cnt-h_back_porch and v_pixel = v_cnt-(v_back_porch-1) when active, else 0. Combinational from the counters.
- Latency: with pixel_tick every clk, coordinates lag the source generator's position by exactly 3 clk.
- Lock:
  - Set on a frame boundary when all of the following hold:
    - new frame_lines equals previous frame_lines
    - every line_len captured during that frame equals the first captured in it
    - no counter saturated
  - Cleared in the same tick on any of the following:
    - a line_len mismatch
    - a frame_lines mismatch
    - either counter reaching saturation
  - After a clear, a fresh full stable frame is required to relock.
- frame_start: 1 for exactly one clk, when pixel_tick=1, locked=1, h_cnt=h_back_porch and v_cnt=v_back_porch-1.
- Simultaneous h and v trailing edges in one tick: v edge is taken into account for that h edge, as defined above.
- pixel_tick=0: counters, edge registers and lock state hold.
- Reset asserted mid-frame: immediate return to the reset state; relock needs two full frames.

Test Plan:
- Reset: hold reset low for 5 clk with toggling syncs -> all outputs 0; after release with syncs idle high, outputs stay 0 and locked=0.
- Loop back the VGA timing generator at 640x480 defaults, pixel_tick=1 every clk -> line_len=800 and frame_lines=525 after the first frame; locked rises at the end of the second full frame; exactly 307200 active clocks per locked frame.
- Same setup, locked -> h_pixel/v_pixel equal the generator's coordinates 3 clk earlier for every active cycle; one frame_start per frame, at (0,0).
- Generator driven with pixel_tick every 4th clk -> same line_len/frame_lines; counters change only on tick cycles.
- While locked, stretch one line by 1 tick -> locked drops on that h trailing edge with line_len=801; relock one stable frame after timing returns to normal.
- Stop h_sync (held high) for 1100 ticks -> h_cnt saturates at 1023, locked=0, active=0; pulse reset mid-frame -> immediate return to reset values.

Source files
------------

// File: rtl/vga_timing_recovery.sv
// Recovers visible-pixel coordinates, an active-video flag and a lock indication from an
// incoming active-low h_sync/v_sync pair, sampled on pixel_tick.
module vga_timing_recovery #(
  parameter int unsigned h_size          = 640,
  parameter int unsigned h_back_porch    = 48,
  parameter int unsigned v_line          = 480,
  parameter int unsigned v_back_porch    = 33,
  parameter int unsigned max_line_ticks  = 1023,
  parameter int unsigned max_frame_lines = 1023,
  localparam int unsigned HpW = $clog2(h_size),
  localparam int unsigned VpW = $clog2(v_line),
  localparam int unsigned HcW = $clog2(max_line_ticks + 1),
  localparam int unsigned VcW = $clog2(max_frame_lines + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pixel_tick,
  input  logic           h_sync,
  input  logic           v_sync,
  output logic [HpW-1:0] h_pixel,
  output logic [VpW-1:0] v_pixel,
  output logic           active,
  output logic           locked,
  output logic           frame_start,
  output logic [HcW-1:0] line_len,
  output logic [VcW-1:0] frame_lines
);

  localparam logic [HcW-1:0] HMax   = HcW'(max_line_ticks);
  localparam logic [HcW-1:0] HStart = HcW'(h_back_porch);
  localparam logic [HcW-1:0] HEnd   = HcW'(h_back_porch + h_size);
  localparam logic [VcW-1:0] VMax   = VcW'(max_frame_lines);
  localparam logic [VcW-1:0] VStart = VcW'(v_back_porch - 1);
  localparam logic [VcW-1:0] VEnd   = VcW'(v_back_porch - 1 + v_line);

  logic           h_meta_q, h_sync_q, h_prev_q, h_prev_d;
  logic           v_meta_q, v_sync_q, v_prev_q, v_prev_d;
  logic [HcW-1:0] h_cnt_q, h_cnt_d, line_len_q, line_len_d, first_len_q, first_len_d;
  logic [VcW-1:0] v_cnt_q, v_cnt_d, frame_lines_q, frame_lines_d;
  logic           pend_v_q, pend_v_d;
  logic           locked_q, locked_d;
  logic           first_valid_q, first_valid_d;
  logic           frame_ok_q, frame_ok_d;
  logic [HcW-1:0] h_len;
  logic [VcW-1:0] v_len;
  logic           h_edge, v_edge;
  logic           h_in, v_in;

  always_comb begin
    h_len         = (h_cnt_q == HMax) ? HMax : h_cnt_q + 1'b1;
    v_len         = (v_cnt_q == VMax) ? VMax : v_cnt_q + 1'b1;
    h_edge        = pixel_tick && h_sync_q && !h_prev_q;
    v_edge        = pixel_tick && v_sync_q && !v_prev_q;
    h_prev_d      = h_prev_q;
    v_prev_d      = v_prev_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    first_len_d   = first_len_q;
    first_valid_d = first_valid_q;
    frame_ok_d    = frame_ok_q;
    pend_v_d      = pend_v_q;
    locked_d      = locked_q;
    if (pixel_tick) begin
      h_prev_d = h_sync_q;
      v_prev_d = v_sync_q;
      if (v_edge) begin
        pend_v_d = 1'b1;
      end
      if (h_edge) begin
        h_cnt_d    = '0;
        line_len_d = h_len;
        if (first_valid_q && (h_len != first_len_q)) begin
          frame_ok_d = 1'b0;
          locked_d   = 1'b0;
        end
        if (!first_valid_q) begin
          first_valid_d = 1'b1;
          first_len_d   = h_len;
        end
        if (pend_v_q || v_edge) begin
          // Frame boundary: the line just closed still belongs to the old frame.
          v_cnt_d       = '0;
          pend_v_d      = 1'b0;
          frame_lines_d = v_len;
          if (v_len != frame_lines_q) begin
            locked_d = 1'b0;
          end else if (frame_ok_d) begin
            locked_d = 1'b1;
          end
          first_valid_d = 1'b0;
          frame_ok_d    = 1'b1;
        end else begin
          v_cnt_d = v_len;
        end
      end else begin
        h_cnt_d = h_len;
      end
      if ((h_cnt_d == HMax) || (v_cnt_d == VMax)) begin
        locked_d   = 1'b0;
        frame_ok_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_meta_q      <= 1'b1;
      h_sync_q      <= 1'b1;
      v_meta_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      h_prev_q      <= 1'b1;
      v_prev_q      <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      first_len_q   <= '0;
      first_valid_q <= 1'b0;
      frame_ok_q    <= 1'b0;
      pend_v_q      <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      h_meta_q      <= h_sync;
      h_sync_q      <= h_meta_q;
      v_meta_q      <= v_sync;
      v_sync_q      <= v_meta_q;
      h_prev_q      <= h_prev_d;
      v_prev_q      <= v_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      first_len_q   <= first_len_d;
      first_valid_q <= first_valid_d;
      frame_ok_q    <= frame_ok_d;
      pend_v_q      <= pend_v_d;
      locked_q      <= locked_d;
    end
  end

  assign h_in        = (h_cnt_q >= HStart) && (h_cnt_q < HEnd);
  assign v_in        = (v_cnt_q >= VStart) && (v_cnt_q < VEnd);
  assign active      = h_in && v_in && locked_q;
  assign h_pixel     = active ? HpW'(h_cnt_q - HStart) : '0;
  assign v_pixel     = active ? VpW'(v_cnt_q - VStart) : '0;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign frame_start = pixel_tick && locked_q && (h_cnt_q == HStart) && (v_cnt_q == VStart);

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Directed bench for vga_timing_recovery driven by a small VGA-style timing generator;
// coordinates are checked against a queue of generator positions.
module tb_vga_timing_recovery;

  localparam int HSize = 16, HFp = 2, HSw = 3, HBp = 4, HTotal = HSize + HFp + HSw + HBp;
  localparam int VLine = 8, VFp = 1, VSw = 2, VBp = 3, VTotal = VLine + VFp + VSw + VBp;
  localparam int HsLo = HSize + HFp, HsHi = HsLo + HSw;
  localparam int VsLo = VLine + VFp, VsHi = VsLo + VSw;
  localparam int FrameClk = HTotal * VTotal;

  logic       clk = 1'b0;
  logic       reset, pixel_tick, h_sync, v_sync;
  logic [3:0] h_pixel;
  logic [2:0] v_pixel;
  logic       active, locked, frame_start;
  logic [9:0] line_len, frame_lines;

  vga_timing_recovery #(
    .h_size         (HSize),
    .h_back_porch   (HBp),
    .v_line         (VLine),
    .v_back_porch   (VBp),
    .max_line_ticks (1023),
    .max_frame_lines(1023)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .h_pixel    (h_pixel),
    .v_pixel    (v_pixel),
    .active     (active),
    .locked     (locked),
    .frame_start(frame_start),
    .line_len   (line_len),
    .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic act;
    int   h;
    int   v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0;
  int   hc = 0, vc = 0, tick_div = 1, cyc = 0, boundaries = 0;
  int   act_cnt = 0, fs_cnt = 0, n;
  bit   gen_on = 0, sb_on = 0, stretch = 0, hs_hold = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_h_pixel"}, 32'(h_pixel), 0);
    check({tag, "_v_pixel"}, 32'(v_pixel), 0);
    check({tag, "_active"}, 32'(active), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_line_len"}, 32'(line_len), 0);
    check({tag, "_frame_lines"}, 32'(frame_lines), 0);
  endtask

  task automatic drive_syncs();
    if (!gen_on) begin
      h_sync = 1'b1;
      v_sync = 1'b1;
    end else begin
      h_sync = hs_hold || !(hc >= HsLo && hc < HsHi);
      v_sync = !(vc >= VsLo && vc < VsHi);
    end
  endtask

  task automatic advance();
    if (hc == HTotal - 1 && stretch && vc == 3) begin
      hc++;
      stretch = 0;
    end else if (hc >= HTotal - 1) begin
      hc = 0;
      vc = (vc == VTotal - 1) ? 0 : vc + 1;
    end else begin
      hc++;
    end
    if (vc == VsHi && hc == HsHi) boundaries++;
  endtask

  // One clock: sample DUT, score against the position driven three clocks earlier,
  // then advance the generator if the tick consumed at this edge was high.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (active) act_cnt++;
    if (frame_start) fs_cnt++;
    if (sb_on && sb.size() == 3) begin
      e = sb.pop_front();
      check("sb_active", 32'(active), 32'(e.act));
      check("sb_h_pixel", 32'(h_pixel), e.act ? e.h : 0);
      check("sb_v_pixel", 32'(v_pixel), e.act ? e.v : 0);
      check("sb_frame_start", 32'(frame_start), 32'(e.act && e.h == 0 && e.v == 0));
    end
    if (gen_on && pixel_tick) advance();
    cyc++;
    pixel_tick = (cyc % tick_div) == 0;
    drive_syncs();
    if (sb_on) sb.push_back('{act: (hc < HSize && vc < VLine), h: hc, v: vc});
  endtask

  task automatic wait_lock(input int max_steps);
    n = 0;
    while (!locked && n < max_steps) begin
      step();
      n++;
    end
  endtask

  initial begin
    reset      = 1'b0;
    pixel_tick = 1'b0;
    h_sync     = 1'b1;
    v_sync     = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      h_sync     = ~h_sync;
      v_sync     = ~v_sync;
      pixel_tick = ~pixel_tick;
    end
    check_zero("in_reset");

    gen_on     = 0;
    pixel_tick = 1'b1;
    drive_syncs();
    reset = 1'b1;
    repeat (40) step();
    check_zero("idle");

    // Start generator from the top-left pixel and acquire lock.
    gen_on     = 1;
    hc         = 0;
    vc         = 0;
    boundaries = 0;
    drive_syncs();
    wait_lock(6 * FrameClk);
    check("first_lock", 32'(locked), 1);
    check("first_lock_boundaries", boundaries, 3);
    check("line_len", 32'(line_len), HTotal);
    check("frame_lines", 32'(frame_lines), VTotal);

    act_cnt = 0;
    fs_cnt  = 0;
    repeat (FrameClk) step();
    check("active_per_frame", act_cnt, HSize * VLine);
    check("frame_start_per_frame", fs_cnt, 1);

    sb_on = 1;
    repeat (FrameClk + 3) step();
    sb_on = 0;
    sb.delete();

    // One line stretched by a tick.
    stretch = 1;
    n = 0;
    while (locked && n < 2 * FrameClk) begin
      step();
      n++;
    end
    check("stretch_unlock", 32'(locked), 0);
    check("stretch_line_len", 32'(line_len), HTotal + 1);
    boundaries = 0;
    wait_lock(4 * FrameClk);
    check("stretch_relock", 32'(locked), 1);
    check("stretch_relock_boundaries", boundaries, 2);
    check("stretch_relock_line_len", 32'(line_len), HTotal);

    // h_sync stuck high long enough to saturate the line counter.
    hs_hold = 1;
    repeat (1100) step();
    check("sat_locked", 32'(locked), 0);
    check("sat_active", 32'(active), 0);
    check("sat_h_pixel", 32'(h_pixel), 0);
    hs_hold = 0;
    n = 0;
    while (line_len != 10'd1023 && n < 3 * HTotal) begin
      step();
      n++;
    end
    check("sat_line_len", 32'(line_len), 1023);
    wait_lock(6 * FrameClk);
    check("sat_relock", 32'(locked), 1);

    // Asynchronous reset in the middle of the visible area.
    n = 0;
    while (!(vc == 4 && hc == 5) && n < 2 * FrameClk) begin
      step();
      n++;
    end
    check("pre_reset_active", 32'(active), 1);
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (3) step();
    reset      = 1'b1;
    boundaries = 0;
    step();
    check("post_reset_locked", 32'(locked), 0);
    check("post_reset_line_len", 32'(line_len), 0);
    wait_lock(5 * FrameClk);
    check("reset_relock", 32'(locked), 1);
    check("reset_relock_boundaries", boundaries, 3);

    // Pixel tick every fourth clock.
    tick_div = 4;
    repeat (2 * 4 * FrameClk) step();
    wait_lock(4 * 4 * FrameClk);
    check("tick4_locked", 32'(locked), 1);
    check("tick4_line_len", 32'(line_len), HTotal);
    check("tick4_frame_lines", 32'(frame_lines), VTotal);
    act_cnt = 0;
    fs_cnt  = 0;
    repeat (4 * FrameClk) step();
    check("tick4_active_clks", act_cnt, 4 * HSize * VLine);
    check("tick4_frame_start", fs_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
